// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver: majority-vote bit decisions, optional parity,
// framing/break/overrun detection, one-word valid/ready holding register.
`timescale 1ns/1ps
module uart_rx_os16 #(
  parameter int unsigned rx_sys_clk = 10000000,
  parameter int unsigned baud_rate  = 9600,
  parameter int unsigned data_width = 8
) (
  input  logic                  rx_clk,
  input  logic                  rst,
  input  logic                  baud_en,
  input  logic                  parity_en,
  input  logic                  odd_r_even_parity,
  input  logic                  rx,
  input  logic                  rd_ready,
  output logic [data_width-1:0] data_out,
  output logic                  valid,
  output logic                  framing_error,
  output logic                  parity_error,
  output logic                  break_det,
  output logic                  overrun_error,
  output logic                  busy
);

  localparam int unsigned OS_DIV = rx_sys_clk / (baud_rate * 16);
  localparam int unsigned DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int unsigned BIT_W  = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(data_width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta, rxs;
  logic [DIV_W-1:0]        div_cnt;
  logic                    os_tick, mid, bit_end;
  logic [3:0]              scnt;
  logic                    s7, s8, maj;
  logic [BIT_W-1:0]        bit_idx;
  logic [data_width-1:0]   shreg;
  logic                    par_bit, par_en_q, par_odd_q;
  logic                    brk_now;
  logic                    done, fe_p, pe_p, bk_p;

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst)         div_cnt <= '0;
    else if (baud_en) div_cnt <= os_tick ? '0 : div_cnt + 1'b1;
  end

  assign os_tick = baud_en && (div_cnt == DIV_LAST);
  assign mid     = os_tick && (scnt == 4'd9);
  assign bit_end = os_tick && (scnt == 4'd15);
  // third vote is the live sample taken at the scnt 9 decision tick
  assign maj     = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign brk_now = (shreg == '0) && !(par_en_q && par_bit) && !maj;
  assign busy    = (state_q != IDLE);

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (os_tick && !rxs) state_d = START;
      START: begin
        if (mid && maj)   state_d = IDLE;
        else if (bit_end) state_d = DATA;
      end
      DATA:    if (bit_end && bit_idx == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (mid) state_d = brk_now ? BRK : IDLE;
      BRK:     if (os_tick && rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      scnt      <= '0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      bit_idx   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      done      <= 1'b0;
      fe_p      <= 1'b0;
      pe_p      <= 1'b0;
      bk_p      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE)  scnt <= '0;
      else if (os_tick)     scnt <= scnt + 4'd1;
      if (os_tick && scnt == 4'd7) s7 <= rxs;
      if (os_tick && scnt == 4'd8) s8 <= rxs;
      case (state_q)
        IDLE: if (os_tick && !rxs) begin
          par_en_q  <= parity_en;
          par_odd_q <= odd_r_even_parity;
          bit_idx   <= '0;
          par_bit   <= 1'b0;
        end
        DATA: begin
          if (mid)     shreg   <= {maj, shreg[data_width-1:1]};
          if (bit_end) bit_idx <= bit_idx + 1'b1;
        end
        PARITY: if (mid) par_bit <= maj;
        STOP: if (mid) begin
          done <= 1'b1;
          fe_p <= !maj;
          pe_p <= par_en_q && ((^shreg ^ par_bit) != par_odd_q);
          bk_p <= brk_now;
        end
        default: ;
      endcase
    end
  end

  // a load in the same cycle as a handshake replaces the word rather than overrunning
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      data_out      <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      break_det     <= 1'b0;
      overrun_error <= 1'b0;
    end else if (done && (!valid || rd_ready)) begin
      data_out      <= shreg;
      valid         <= 1'b1;
      framing_error <= fe_p;
      parity_error  <= pe_p;
      break_det     <= bk_p;
      overrun_error <= overrun_error && !(valid && rd_ready);
    end else if (done) begin
      overrun_error <= 1'b1;
    end else if (valid && rd_ready) begin
      valid         <= 1'b0;
      overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed self-checking bench for uart_rx_os16 at default parameters (1040-cycle bits).
`timescale 1ns/1ps
module tb_uart_rx_os16;

  localparam int BIT = 1040;

  logic       clk = 1'b0;
  logic       rst, baud_en, parity_en, odd_r_even_parity, rx, rd_ready;
  logic [7:0] data_out;
  logic       valid, framing_error, parity_error, break_det, overrun_error, busy;

  int n_cmp = 0;
  int n_err = 0;
  int vtot  = 0;
  int g_cnt = 0;
  logic [7:0] cap_data;
  logic       cap_fe, cap_pe, cap_bk;

  uart_rx_os16 dut (
    .rx_clk            (clk),
    .rst               (rst),
    .baud_en           (baud_en),
    .parity_en         (parity_en),
    .odd_r_even_parity (odd_r_even_parity),
    .rx                (rx),
    .rd_ready          (rd_ready),
    .data_out          (data_out),
    .valid             (valid),
    .framing_error     (framing_error),
    .parity_error      (parity_error),
    .break_det         (break_det),
    .overrun_error     (overrun_error),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      vtot++;
      cap_data = data_out;
      cap_fe   = framing_error;
      cap_pe   = parity_error;
      cap_bk   = break_det;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // glitch flips rx for the one cycle that lands in the scnt 8 sample
  task automatic drive_bit(input logic b, input logic glitch);
    for (int c = 0; c < BIT; c++) begin
      if (glitch && dut.scnt == 4'd8 && dut.div_cnt == 7'd62) begin
        rx = ~b;
        g_cnt++;
      end else begin
        rx = b;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic stop_b, input int glitch_bit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch_bit == i);
    if (has_par) drive_bit(pbit, 1'b0);
    drive_bit(stop_b, 1'b0);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    for (int c = 0; c < limit && busy; c++) @(negedge clk);
  endtask

  initial begin
    int  v0;
    logic saw_busy;
    rst = 1'b0; baud_en = 1'b1; parity_en = 1'b0; odd_r_even_parity = 1'b0;
    rx = 1'b1; rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun_error, 0);
    rst = 1'b1;
    repeat (100) @(negedge clk);

    // 250 odd parity, parity bit 1
    parity_en = 1'b1; odd_r_even_parity = 1'b1;
    v0 = vtot;
    send_frame(8'd250, 1'b1, 1'b1, 1'b1, -1);
    repeat (BIT / 8) @(negedge clk);
    check("t1_vcycles", vtot - v0, 1);
    check("t1_data", cap_data, 250);
    check("t1_fe", cap_fe, 0);
    check("t1_pe", cap_pe, 0);
    check("t1_bk", cap_bk, 0);
    check("t1_valid_low", valid, 0);

    // 96 even parity with wrong parity bit
    odd_r_even_parity = 1'b0;
    v0 = vtot;
    send_frame(8'd96, 1'b1, 1'b1, 1'b1, -1);
    repeat (BIT / 8) @(negedge clk);
    check("t2_vcycles", vtot - v0, 1);
    check("t2_data", cap_data, 96);
    check("t2_pe", cap_pe, 1);
    check("t2_fe", cap_fe, 0);

    // 69 no parity, stop bit 0, glitch inside data bit 0
    parity_en = 1'b0;
    v0 = vtot;
    send_frame(8'd69, 1'b0, 1'b0, 1'b0, 0);
    wait_idle(2 * BIT);
    check("t3_idle", busy, 0);
    check("t3_glitch_hit", g_cnt, 1);
    check("t3_vcycles", vtot - v0, 1);
    check("t3_data", cap_data, 69);
    check("t3_fe", cap_fe, 1);
    check("t3_bk", cap_bk, 0);

    // 300-cycle false start
    repeat (BIT / 4) @(negedge clk);
    v0 = vtot;
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    rx = 1'b1;
    wait_idle(BIT - 300);
    check("fs_saw_busy", saw_busy, 1);
    check("fs_busy_back", busy, 0);
    check("fs_no_valid", vtot - v0, 0);

    // overrun
    rd_ready = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    repeat (BIT / 8) @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
    repeat (BIT / 8) @(negedge clk);
    check("ovr_valid", valid, 1);
    check("ovr_data", data_out, 8'hA5);
    check("ovr_flag", overrun_error, 1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check("ovr_clr_valid", valid, 0);
    check("ovr_clr_flag", overrun_error, 0);
    check("ovr_hold_data", data_out, 8'hA5);

    // break: 12 bit times low
    repeat (BIT / 4) @(negedge clk);
    rx = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    check("brk_det", break_det, 1);
    check("brk_fe", framing_error, 1);
    check("brk_data", data_out, 0);
    check("brk_valid", valid, 1);
    check("brk_busy", busy, 1);
    rx = 1'b1;
    wait_idle(200);
    check("brk_release", busy, 0);

    // reset in the middle of DATA
    repeat (BIT / 4) @(negedge clk);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("mr_data", data_out, 0);
    check("mr_valid", valid, 0);
    check("mr_fe", framing_error, 0);
    check("mr_pe", parity_error, 0);
    check("mr_bk", break_det, 0);
    check("mr_ovr", overrun_error, 0);
    check("mr_busy", busy, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- Oversampling UART receiver: 16x sampling, majority-vote bit decisions, optional parity check, framing/break/overrun detection.
- Delivers each received word to downstream logic through a valid/ready handshake with a one-word holding register.
- Sits on the rx_clk domain, on the receive side of the uart top, opposite the transmitter that drives the serial line.

Parameters:
- rx_sys_clk, 10000000, rx_clk frequency in Hz.
- baud_rate, 9600, line bit rate.
- data_width, 8, data bits per frame, sent LSB first.
- Derived: OS_DIV = rx_sys_clk/(baud_rate*16), truncated. Default is 65, giving 1040 rx_clk cycles per bit.

Ports:
- rx_clk  in  1  receiver clock.
- rst  in  1  asynchronous active-low reset.
- baud_en  in  1  enables the oversample divider; 0 freezes the divider and FSM.
- parity_en  in  1  frame carries a parity bit.
- odd_r_even_parity  in  1  1 = odd parity, 0 = even parity.
- rx  in  1  asynchronous serial input; idles high.
- rd_ready  in  1  consumer accepts data_out this cycle.
- data_out  out  data_width  received word.
- valid  out  1  data_out and its per-frame error flags are valid.
- framing_error  out  1  stop bit sampled 0; per-frame flag.
- parity_error  out  1  parity mismatch; per-frame flag.
- break_det  out  1  break frame seen; per-frame flag.
- overrun_error  out  1  sticky: a frame was dropped because valid was still high.
- busy  out  1  FSM is outside IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - Both synchroniser flops = 1; divider = 0; sample count = 0; state = IDLE.
  - data_out = 0; valid, framing_error, parity_error, break_det, overrun_error, busy = 0.
- Input synchronisation: rx passes through 2 flops; all logic uses the synchronised value rxs.
- Oversample tick:
  - Divider counts 0..OS_DIV-1 while baud_en=1; os_tick is a 1-cycle pulse at OS_DIV-1.
  - baud_en=0 holds the divider and all state; nothing advances.
- Bit timing:
  - scnt runs 0..15 per bit, advancing on os_tick.
  - rxs is captured at scnt 7, 8 and 9.
  - Bit value is the majority of the three samples, decided at scnt 9.
  - The bit ends at scnt 15.
- States:
  - IDLE: on os_tick with rxs=0 -> START, scnt=0. parity_en and odd_r_even_parity are latched at this transition; changes mid-frame are ignored.
  - START: at the decision point, majority=1 is a false start -> IDLE with no output. Majority=0 -> DATA at bit end.
  - DATA: data_width bits shifted in LSB first; after the last bit -> PARITY if the latched parity_en=1, else STOP.
  - PARITY: error when XOR(data bits, parity bit) != latched odd_r_even_parity.
  - STOP: at the decision point (scnt 9), go to IDLE, or to BREAK if a break is detected. The remaining 6 ticks are not waited, so a following start bit is caught early.
  - BREAK: stays until rxs=1, then -> IDLE. busy stays 1 throughout.
- Break condition: all data bits 0, parity bit 0 (if present) and stop bit 0. break_det=1 and framing_error=1 are reported together.
- Output, 1 cycle after the stop decision:
  - If valid=0: load data_out and the three per-frame flags, set valid=1.
  - If valid=1: the frame is discarded, overrun_error=1, and data_out and flags are unchanged.
  - Break frames follow the same rule.
- Handshake:
  - valid && rd_ready in a cycle clears valid at the next edge.
  - The same handshake clears overrun_error.
  - data_out holds its value after the handshake.
  - If the handshake and a new frame load fall in the same cycle, the load wins: valid stays 1, new data is loaded, and no overrun is flagged.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.

Test Plan:
- 8'd250, parity_en=1, odd (parity bit 1), 1040-cycle bits, rd_ready=1 -> data_out=250, valid pulses 1 cycle, no error flags set.
- 8'd96 with even parity but parity bit forced to 1 -> data_out=96, valid=1, parity_error=1, framing_error=0.
- 8'd69, parity_en=0, stop bit driven 0 -> data_out=69, framing_error=1, break_det=0.
- Glitches and false starts:
  - A 300-cycle low pulse on idle rx -> no valid, busy returns to 0 within one bit.
  - A single-sample 1-cycle glitch at scnt 8 inside a data bit -> bit value unchanged.
- Overrun: rd_ready=0, send 8'hA5 then 8'h3C -> data_out=8'hA5, overrun_error=1. Then rd_ready=1 for 1 cycle -> valid=0, overrun_error=0.
- Break and reset:
  - Line held low for 12 bit times, no parity -> break_det=1, framing_error=1, data_out=0, busy=1 until rx rises.
  - rst pulsed low mid-DATA -> all outputs 0 immediately.
